// File: rtl/router_fifo_reader.sv
// router_fifo_reader: read-side engine for one router output FIFO.
// Pulls 9-bit words (bit8 = header flag) with 1-cycle read latency, frames
// header + N payload + parity packets into a 2-entry skid buffer, and drives
// a valid/ready byte stream with sop/eop. Flags parity and framing errors, and
// issues a one-cycle soft reset to the FIFO when the downstream stalls too long.
// Optional statistics counters are enabled by defining ROUTER_RD_STATS_EN.
module router_fifo_reader #(
  parameter int TIMEOUT = 30,
  parameter int TO_W    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_emp,
  input  logic [8:0]  fifo_data,
  output logic        fifo_rd_en,
  output logic        rstsoft,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sop,
  output logic        out_eop,
  output logic        parity_err,
  output logic        frame_err,
  output logic        busy
`ifdef ROUTER_RD_STATS_EN
  ,
  output logic [15:0] pkt_cnt,
  output logic [15:0] err_cnt
`endif
);

  localparam int DEPTH = 2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_PARITY  = 2'd2
  } state_t;

  // One skid-buffer slot; perr is precomputed so parity_err lines up with the eop transfer.
  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic       perr;
  } entry_t;

  state_t                  state_reg, state_next;
  logic [5:0]              cnt_reg, cnt_next;
  logic [7:0]              par_reg, par_next;
  logic [1:0]              occ_reg, occ_next;
  logic [1:0]              occ_after_pop;
  logic                    inflight_reg;
  logic [TO_W-1:0]         stall_reg;
  entry_t [DEPTH-1:0]      buf_reg;
  entry_t [DEPTH-1:0]      buf_next;
  entry_t                  head;
  entry_t                  push_ent;
  logic                    push;
  logic                    pop;
  logic                    frame_viol;
  logic                    wr_idx;
  logic [2:0]              level;

  assign head       = buf_reg[0];
  // The stall counter sitting at TIMEOUT is the soft-reset cycle itself.
  assign rstsoft    = (stall_reg == TO_W'(TIMEOUT));
  // Hold the stream idle during the soft-reset cycle so nothing is handed
  // downstream that is about to be flushed.
  assign out_valid  = (occ_reg != 2'd0) && !rstsoft;
  assign out_data   = out_valid ? head.data : 8'h00;
  assign out_sop    = out_valid & head.sop;
  assign out_eop    = out_valid & head.eop;
  assign pop        = out_valid & out_ready;
  assign parity_err = pop & head.eop & head.perr;
  assign frame_err  = frame_viol;
  assign busy       = (state_reg != S_IDLE);

  // Slots committed next cycle, net of this cycle's pop, so a steady
  // read/push/pop pipeline keeps one byte per cycle flowing.
  assign level      = {1'b0, occ_reg} + {2'b00, inflight_reg} - {2'b00, pop};
  assign fifo_rd_en = !rst && !fifo_emp && !rstsoft && (level < 3'd2);

  // Occupancy after the pop decides where a returning word lands.
  assign occ_after_pop = occ_reg - {1'b0, pop};
  assign wr_idx        = occ_after_pop[0];
  assign occ_next      = occ_after_pop + {1'b0, push};

  // Classify the returning FIFO word and compute packet-framing next state.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    par_next   = par_reg;
    push       = 1'b0;
    push_ent   = '0;
    frame_viol = 1'b0;
    if (inflight_reg && !rstsoft) begin
      if (fifo_data[8]) begin
        // A header always starts a fresh packet; mid-packet it aborts the old one.
        frame_viol    = (state_reg != S_IDLE);
        push          = 1'b1;
        push_ent.data = fifo_data[7:0];
        push_ent.sop  = 1'b1;
        par_next      = fifo_data[7:0];
        cnt_next      = fifo_data[7:2];
        state_next    = (fifo_data[7:2] != 6'd0) ? S_PAYLOAD : S_PARITY;
      end else begin
        case (state_reg)
          S_IDLE: begin
            frame_viol = 1'b1;
          end
          S_PAYLOAD: begin
            push          = 1'b1;
            push_ent.data = fifo_data[7:0];
            par_next      = par_reg ^ fifo_data[7:0];
            cnt_next      = cnt_reg - 6'd1;
            if (cnt_reg == 6'd1) begin
              state_next = S_PARITY;
            end
          end
          S_PARITY: begin
            push          = 1'b1;
            push_ent.data = fifo_data[7:0];
            push_ent.eop  = 1'b1;
            push_ent.perr = (fifo_data[7:0] != par_reg);
            state_next    = S_IDLE;
          end
          default: begin
            state_next = S_IDLE;
          end
        endcase
      end
    end
  end

  // Per-slot next value: a push into this slot wins, otherwise shift toward the head on pop.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    entry_t shift_src;
    if (gi < DEPTH - 1) begin : g_shift
      assign shift_src = buf_reg[gi+1];
    end else begin : g_hold
      assign shift_src = buf_reg[gi];
    end
    assign buf_next[gi] = (push && (int'(wr_idx) == gi)) ? push_ent :
                          (pop ? shift_src : buf_reg[gi]);
  end

  // Skid buffer storage and occupancy; soft reset flushes both.
  always_ff @(posedge clk) begin
    if (rst || rstsoft) begin
      buf_reg <= '0;
      occ_reg <= 2'd0;
    end else begin
      buf_reg <= buf_next;
      occ_reg <= occ_next;
    end
  end

  // Framing state, payload countdown and running parity.
  always_ff @(posedge clk) begin
    if (rst || rstsoft) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 6'd0;
      par_reg   <= 8'h00;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      par_reg   <= par_next;
    end
  end

  // Track the outstanding read; rd_en is already low during reset and soft reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_reg <= 1'b0;
    end else begin
      inflight_reg <= fifo_rd_en;
    end
  end

  // Count consecutive stalled cycles; any transfer or idle stream clears it.
  always_ff @(posedge clk) begin
    if (rst || rstsoft) begin
      stall_reg <= '0;
    end else if (out_valid && !out_ready) begin
      stall_reg <= stall_reg + TO_W'(1);
    end else begin
      stall_reg <= '0;
    end
  end

`ifdef ROUTER_RD_STATS_EN
  // Saturating packet and error event counters, cleared only by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt <= 16'h0000;
      err_cnt <= 16'h0000;
    end else begin
      if (pop && head.eop && (pkt_cnt != 16'hFFFF)) begin
        pkt_cnt <= pkt_cnt + 16'd1;
      end
      if ((parity_err || frame_err || rstsoft) && (err_cnt != 16'hFFFF)) begin
        err_cnt <= err_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_router_fifo_reader.sv
// Testbench for router_fifo_reader: a queue-based FIFO model with 1-cycle read
// latency feeds the DUT; expected stream bytes are built per packet from the
// framing rules and compared at each transfer.
module tb_router_fifo_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       fifo_emp;
  logic [8:0] fifo_data;
  logic       fifo_rd_en;
  logic       rstsoft;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_sop;
  logic       out_eop;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  always #5 clk = ~clk;

  router_fifo_reader dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_emp   (fifo_emp),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .rstsoft    (rstsoft),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  typedef struct packed {
    logic       perr;
    logic       sop;
    logic       eop;
    logic [7:0] b;
  } exp_t;

  logic [8:0] fq[$];
  exp_t       eq[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  logic [8:0] pend;
  bit   pend_v = 1'b0;
  int   ferr_seen, rs_seen, perr_seen, xfer_cnt, eop_cnt;
  int   first_xfer, last_xfer, stall_run, stall_at_rs, exp_perr;
  logic [15:0] snap_all;
  bit   snap_valid, snap_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive inputs on the falling edge, sample just after.
  task automatic step(input bit rdy, input bit r = 1'b0);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst       = r;
    out_ready = rdy;
    fifo_data = pend_v ? pend : 9'($urandom);
    pend_v    = 1'b0;
    fifo_emp  = (fq.size() == 0);
    #1;
    cyc++;
    snap_all   = {fifo_rd_en, rstsoft, out_valid, out_sop, out_eop,
                  parity_err, frame_err, busy, out_data};
    snap_valid = out_valid;
    snap_busy  = busy;
    chk("rd_en_while_empty", 32'(fifo_rd_en & fifo_emp), 0);
    chk("perr_outside_eop", 32'(parity_err & !(out_valid & out_ready & out_eop)), 0);
    if (fifo_rd_en && fq.size() > 0) begin
      pend   = fq.pop_front();
      pend_v = 1'b1;
    end
    if (out_valid && out_ready) begin
      got = {parity_err, out_sop, out_eop, out_data};
      xfer_cnt++;
      if (parity_err) perr_seen++;
      if (first_xfer < 0) first_xfer = cyc;
      last_xfer = cyc;
      chk("xfer_has_expectation", 32'(eq.size() > 0), 1);
      if (eq.size() > 0) begin
        e = eq.pop_front();
        chk("xfer_byte", {21'b0, got}, {21'b0, e});
        if (e.eop) begin
          eop_cnt++;
          $display("[TB] packet %0d end: parity byte %02h perr %0b at cycle %0d",
                   eop_cnt, out_data, parity_err, cyc);
        end
      end
    end
    if (frame_err) ferr_seen++;
    if (rstsoft) begin
      rs_seen++;
      stall_at_rs = stall_run;
      chk("rd_en_in_rstsoft", 32'(fifo_rd_en), 0);
      fq.delete();
      pend_v = 1'b0;
    end
    if (out_valid && !out_ready) stall_run++;
    else stall_run = 0;
    @(posedge clk);
  endtask

  task automatic clear_stats();
    ferr_seen = 0; rs_seen = 0; perr_seen = 0; xfer_cnt = 0; eop_cnt = 0;
    first_xfer = -1; last_xfer = -1; stall_run = 0; stall_at_rs = -1; exp_perr = 0;
  endtask

  task automatic add_w(input logic [8:0] w);
    fq.push_back(w);
  endtask

  task automatic add_e(input logic perr, input logic sop, input logic eop, input logic [7:0] b);
    exp_t e;
    e = {perr, sop, eop, b};
    eq.push_back(e);
  endtask

  // Well-formed packet with N payload bytes; parity optionally corrupted.
  task automatic add_rand_pkt(input logic [5:0] n, input bit bad);
    logic [7:0] hb, b, x;
    hb = {n, 2'($urandom)};
    add_w({1'b1, hb});
    add_e(1'b0, 1'b1, 1'b0, hb);
    x = hb;
    for (int i = 0; i < int'(n); i++) begin
      b = 8'($urandom);
      add_w({1'b0, b});
      add_e(1'b0, 1'b0, 1'b0, b);
      x = x ^ b;
    end
    b = bad ? (x ^ 8'($urandom_range(1, 255))) : x;
    add_w({1'b0, b});
    add_e(bad, 1'b0, 1'b1, b);
    if (bad) exp_perr++;
  endtask

  // Run until every queued word is consumed and every expected byte seen.
  task automatic drain(input bit rnd, input int budget);
    int n;
    n = 0;
    while ((eq.size() != 0 || fq.size() != 0 || pend_v || snap_valid) && n < budget) begin
      step(rnd ? bit'($urandom_range(0, 1)) : 1'b1);
      n++;
    end
    chk("drain_within_budget", 32'(n < budget), 1);
    chk("expected_all_seen", 32'(eq.size()), 0);
    step(1'b1);
    step(1'b1);
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b0; fifo_emp = 1'b1; fifo_data = 9'h000;
    clear_stats();

    // Reset: words already waiting in the FIFO must not be read.
    add_w(9'h10C); add_w(9'h011); add_w(9'h022); add_w(9'h033); add_w(9'h00C);
    step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1);
    chk("reset_outputs", {16'b0, snap_all}, 0);
    $display("[TB] reset held 3 cycles, outputs %04h", snap_all);

    // Test 1: nominal packet at full rate.
    add_e(1'b0, 1'b1, 1'b0, 8'h0C); add_e(1'b0, 1'b0, 1'b0, 8'h11);
    add_e(1'b0, 1'b0, 1'b0, 8'h22); add_e(1'b0, 1'b0, 1'b0, 8'h33);
    add_e(1'b0, 1'b0, 1'b1, 8'h0C);
    drain(1'b0, 40);
    chk("t1_xfer_count", 32'(xfer_cnt), 5);
    chk("t1_consecutive", 32'(last_xfer - first_xfer), 4);
    chk("t1_no_perr", 32'(perr_seen), 0);
    $display("[TB] test1 nominal packet: %0d transfers span %0d cycles", xfer_cnt, last_xfer - first_xfer + 1);

    // Test 2: same packet, bad parity byte.
    clear_stats();
    add_w(9'h10C); add_w(9'h011); add_w(9'h022); add_w(9'h033); add_w(9'h0FF);
    add_e(1'b0, 1'b1, 1'b0, 8'h0C); add_e(1'b0, 1'b0, 1'b0, 8'h11);
    add_e(1'b0, 1'b0, 1'b0, 8'h22); add_e(1'b0, 1'b0, 1'b0, 8'h33);
    add_e(1'b1, 1'b0, 1'b1, 8'hFF);
    drain(1'b0, 40);
    chk("t2_perr_count", 32'(perr_seen), 1);
    $display("[TB] test2 bad parity: parity_err pulses %0d", perr_seen);

    // Test 3: zero-length payload.
    clear_stats();
    add_w(9'h100); add_w(9'h000);
    add_e(1'b0, 1'b1, 1'b0, 8'h00); add_e(1'b0, 1'b0, 1'b1, 8'h00);
    drain(1'b0, 40);
    chk("t3_xfer_count", 32'(xfer_cnt), 2);
    chk("t3_busy_after", 32'(snap_busy), 0);
    $display("[TB] test3 N=0 packet: %0d transfers, busy %0b", xfer_cnt, snap_busy);

    // Test 4: downstream never ready -> soft reset after TIMEOUT stalled cycles.
    clear_stats();
    add_w(9'h10C); add_w(9'h011); add_w(9'h022); add_w(9'h033); add_w(9'h00C);
    for (int i = 0; i < 45; i++) begin
      step(1'b0);
      if (i == 10) chk("t4_busy_mid", 32'(snap_busy), 1);
    end
    chk("t4_rstsoft_count", 32'(rs_seen), 1);
    chk("t4_stall_cycles", 32'(stall_at_rs), 30);
    chk("t4_valid_after", 32'(snap_valid), 0);
    chk("t4_busy_after", 32'(snap_busy), 0);
    $display("[TB] test4 timeout: rstsoft pulses %0d after %0d stalled cycles", rs_seen, stall_at_rs);

    // Test 5: stray payload word in IDLE, then a header inside a payload.
    clear_stats();
    add_w(9'h055);
    add_w(9'h108); add_w(9'h0AA); add_w(9'h104); add_w(9'h05A); add_w(9'h05E);
    add_e(1'b0, 1'b1, 1'b0, 8'h08); add_e(1'b0, 1'b0, 1'b0, 8'hAA);
    add_e(1'b0, 1'b1, 1'b0, 8'h04); add_e(1'b0, 1'b0, 1'b0, 8'h5A);
    add_e(1'b0, 1'b0, 1'b1, 8'h5E);
    drain(1'b0, 60);
    chk("t5_frame_err_count", 32'(ferr_seen), 2);
    chk("t5_eop_count", 32'(eop_cnt), 1);
    $display("[TB] test5 framing errors: frame_err pulses %0d, eops %0d", ferr_seen, eop_cnt);

    // Test 6: 200 random packets, random backpressure.
    clear_stats();
    add_rand_pkt(6'd63, 1'b0);
    add_rand_pkt(6'd0, 1'b1);
    for (int p = 2; p < 200; p++) begin
      add_rand_pkt(6'($urandom_range(0, 63)), ($urandom_range(0, 7) == 0));
    end
    drain(1'b1, 60000);
    chk("t6_eop_count", 32'(eop_cnt), 200);
    chk("t6_perr_count", 32'(perr_seen), 32'(exp_perr));
    chk("t6_no_frame_err", 32'(ferr_seen), 0);
    chk("t6_no_rstsoft", 32'(rs_seen), 0);
    $display("[TB] test6 random: %0d packets, %0d bytes, %0d parity errors", eop_cnt, xfer_cnt, perr_seen);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
